// File: rtl/mac_layer_ctrl.sv
// Layer sequencer for a sign-magnitude MAC: fetches one weight row per neuron,
// activates the MAC result (ReLU, shift, saturate) and hands it out over valid/ready.
module mac_layer_ctrl #(
    parameter int MAX_NEURONS = 62,
    parameter int SHIFT       = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [5:0]               layer_size,
    input  logic [8*MAX_NEURONS-1:0] act_in,
    output logic                     w_rd_en,
    output logic [5:0]               w_addr,
    input  logic [8*MAX_NEURONS-1:0] w_data,
    output logic [8*MAX_NEURONS-1:0] mac_a,
    output logic [8*MAX_NEURONS-1:0] mac_w,
    input  logic [20:0]              mac_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [5:0]               res_idx,
    output logic [7:0]               res_data,
    output logic                     busy,
    output logic                     done
);

    // state | meaning
    // IDLE  | waiting for start
    // FETCH | read strobe for weight row idx
    // LOAD  | capture w_data into mac_w
    // CALC  | register activated mac_out
    // WRITE | present result until res_ready
    // FIN   | one-cycle done pulse
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        CALC  = 3'd3,
        WRITE = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [5:0] MAXN = 6'(MAX_NEURONS);

    state_t     state, state_nxt;
    logic [5:0] idx;
    logic [5:0] n;
    logic [5:0] n_clamped;
    logic       last;
    logic [19:0] mag_shifted;
    logic [7:0]  act_val;

    assign n_clamped   = (layer_size > MAXN) ? MAXN : layer_size;
    assign last        = (idx == n - 6'd1);
    assign w_addr      = idx;
    assign mag_shifted = mac_out[19:0] >> SHIFT;

    // Negative results (including the negative zero the MAC returns) clip to 0.
    always_comb begin
        act_val = 8'h00;
        if (!mac_out[20]) begin
            if (mag_shifted > 20'd127) act_val = 8'h7F;
            else                       act_val = {1'b0, mag_shifted[6:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (n_clamped != 6'd0) ? FETCH : FIN;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = CALC;
            CALC:    state_nxt = WRITE;
            WRITE:   if (res_ready) state_nxt = last ? FIN : FETCH;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_rd_en   = (state == FETCH);
        res_valid = (state == WRITE);
        busy      = (state != IDLE);
        done      = (state == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            n        <= '0;
            mac_a    <= '0;
            mac_w    <= '0;
            res_data <= '0;
            res_idx  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mac_a <= act_in;
                    n     <= n_clamped;
                    idx   <= '0;
                end
                LOAD: mac_w <= w_data;
                CALC: begin
                    res_data <= act_val;
                    res_idx  <= idx;
                end
                WRITE: if (res_ready && !last) idx <= idx + 6'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_layer_ctrl.sv
// Directed bench for mac_layer_ctrl: a registered weight memory, a table-driven
// MAC model and a result log, checked with immediate assertions.
module tb_mac_layer_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [5:0]   layer_size;
    logic [495:0] act_in;
    logic         w_rd_en;
    logic [5:0]   w_addr;
    logic [495:0] w_data;
    logic [495:0] mac_a;
    logic [495:0] mac_w;
    logic [20:0]  mac_out;
    logic         res_valid;
    logic         res_ready;
    logic [5:0]   res_idx;
    logic [7:0]   res_data;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [20:0] mac_tab [64];
    int rd_cnt = 0, rv_cnt = 0, done_cnt = 0;
    logic [5:0] log_idx[$];
    logic [7:0] log_data[$];

    always #5 clk = ~clk;

    mac_layer_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer_size(layer_size),
        .act_in(act_in), .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
        .mac_a(mac_a), .mac_w(mac_w), .mac_out(mac_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data),
        .busy(busy), .done(done)
    );

    // Weight row r is 62 copies of {2'b01, r}; the MAC model keys off mac_w[5:0].
    always @(posedge clk) if (w_rd_en) w_data <= {62{2'b01, w_addr}};
    assign mac_out = mac_tab[mac_w[5:0]];

    always @(posedge clk) begin
        if (w_rd_en)   rd_cnt   <= rd_cnt + 1;
        if (res_valid) rv_cnt   <= rv_cnt + 1;
        if (done)      done_cnt <= done_cnt + 1;
        if (res_valid && res_ready) begin
            log_idx.push_back(res_idx);
            log_data.push_back(res_data);
        end
    end

    task automatic chk(input string tag, input logic [495:0] obs, input logic [495:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic kick(input logic [5:0] size, input logic [495:0] act);
        log_idx.delete();
        log_data.delete();
        layer_size = size;
        act_in     = act;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        act_in     = ~act;
    endtask

    // cyc counts negedges after the accepting edge until done is seen.
    task automatic wait_done(input int bound, output int cyc);
        cyc = 1;
        while (!done && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    initial begin
        int cyc;
        int rd0, rv0, dn0;
        logic [5:0] hold_idx;
        logic [7:0] hold_data;
        logic [495:0] act;

        rst_n = 1'b0; start = 1'b0; layer_size = '0; act_in = '0;
        res_ready = 1'b1; w_data = '0;
        for (int i = 0; i < 64; i++) mac_tab[i] = '0;
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_rdy_outs", {w_rd_en, res_valid, done}, 3'b000);
        chk("reset_res", {res_idx, res_data}, 14'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Three neurons: +256, +20000, -5
        mac_tab[0] = 21'd256; mac_tab[1] = 21'd20000; mac_tab[2] = 21'h100005;
        act = {62{8'h5A}} ^ 496'h1234_5678_9ABC;
        kick(6'd3, act);
        chk("busy_after_start", busy, 1'b1);
        chk("first_fetch", {w_rd_en, w_addr}, {1'b1, 6'd0});
        wait_done(40, cyc);
        chk("done_latency", cyc, 13);
        chk("mac_a_held", mac_a, act);
        chk("n3_count", log_idx.size(), 3);
        if (log_idx.size() == 3) begin
            chk("n3_idx0", {log_idx[0], log_data[0]}, {6'd0, 8'h02});
            chk("n3_idx1", {log_idx[1], log_data[1]}, {6'd1, 8'h7F});
            chk("n3_idx2", {log_idx[2], log_data[2]}, {6'd2, 8'h00});
        end
        @(negedge clk);
        chk("done_one_cycle", {done, busy}, 2'b00);

        // Negative zero and saturation boundaries
        mac_tab[0] = 21'h100000; mac_tab[1] = 21'd16383; mac_tab[2] = 21'd16384;
        mac_tab[3] = 21'd128;    mac_tab[4] = 21'h0FFFFF;
        kick(6'd5, act);
        wait_done(60, cyc);
        chk("sat_count", log_idx.size(), 5);
        if (log_idx.size() == 5) begin
            chk("neg_zero", log_data[0], 8'h00);
            chk("mag_127", log_data[1], 8'h7F);
            chk("mag_128_clamp", log_data[2], 8'h7F);
            chk("mag_1", log_data[3], 8'h01);
            chk("mag_max_clamp", log_data[4], 8'h7F);
        end
        @(negedge clk);

        // Consumer stall in WRITE
        mac_tab[0] = 21'd640; mac_tab[1] = 21'd1280;
        res_ready = 1'b0;
        kick(6'd2, act);
        cyc = 0;
        while (!res_valid && cyc < 10) begin @(negedge clk); cyc++; end
        chk("stall_valid_seen", res_valid, 1'b1);
        hold_idx = res_idx; hold_data = res_data;
        chk("stall_first", {hold_idx, hold_data}, {6'd0, 8'h05});
        rd0 = rd_cnt;
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("stall_held", {res_valid, res_idx, res_data}, {1'b1, hold_idx, hold_data});
        chk("stall_no_read", rd_cnt, rd0);
        res_ready = 1'b1;
        wait_done(20, cyc);
        chk("stall_count", log_idx.size(), 2);
        if (log_idx.size() == 2)
            chk("stall_second", {log_idx[1], log_data[1]}, {6'd1, 8'h0A});
        @(negedge clk);

        // Empty layer
        rd0 = rd_cnt; rv0 = rv_cnt; dn0 = done_cnt;
        kick(6'd0, act);
        wait_done(4, cyc);
        chk("empty_done", done, 1'b1);
        @(negedge clk);
        chk("empty_done_cnt", done_cnt - dn0, 1);
        chk("empty_no_read", rd_cnt - rd0, 0);
        chk("empty_no_result", rv_cnt - rv0, 0);

        // Oversized layer clamps to 62
        for (int i = 0; i < 64; i++) mac_tab[i] = 21'(i << 7);
        kick(6'd63, act);
        wait_done(400, cyc);
        chk("clamp_done", done, 1'b1);
        chk("clamp_count", log_idx.size(), 62);
        if (log_idx.size() == 62)
            for (int i = 0; i < 62; i++)
                chk($sformatf("clamp_res%0d", i), {log_idx[i], log_data[i]}, {6'(i), 8'(i)});
        @(negedge clk);

        // Reset during LOAD of neuron 5
        kick(6'd10, act);
        cyc = 0;
        while (!(w_rd_en && w_addr == 6'd5) && cyc < 40) begin @(negedge clk); cyc++; end
        chk("reach_fetch5", {w_rd_en, w_addr}, {1'b1, 6'd5});
        dn0 = done_cnt;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {busy, done, w_rd_en, res_valid}, 4'b0000);
        chk("arst_res", {res_idx, res_data, w_addr}, 20'd0);
        chk("arst_mac_a", mac_a, '0);
        chk("arst_mac_w", mac_w, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rv0 = rv_cnt;
        repeat (3) @(negedge clk);
        chk("arst_no_done", done_cnt, dn0);
        chk("arst_no_valid", rv_cnt, rv0);
        chk("arst_idle", busy, 1'b0);
        kick(6'd2, act);
        chk("restart_fetch0", {w_rd_en, w_addr}, {1'b1, 6'd0});
        wait_done(20, cyc);
        chk("restart_count", log_idx.size(), 2);
        if (log_idx.size() == 2)
            chk("restart_idx", {log_idx[0], log_idx[1]}, {6'd0, 6'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
